// File: rtl/tinylab_alu_pkg.sv
// Shared definitions for the slice-serial ALU: function codes and FSM state encoding.
package tinylab_alu_pkg;

  typedef logic [2:0] alu_func_t;

  localparam alu_func_t ALU_MOVEB = 3'b000;
  localparam alu_func_t ALU_ADD   = 3'b001;
  localparam alu_func_t ALU_SUB   = 3'b010;
  localparam alu_func_t ALU_AND   = 3'b011;
  localparam alu_func_t ALU_OR    = 3'b100;

  // DONE is the only state with bit 1 set, so alu_end decodes to a single flop bit.
  typedef enum logic [1:0] {
    ALU_IDLE = 2'd0,
    ALU_BUSY = 2'd1,
    ALU_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE_W-bit ALU unit; the serial top reuses one instance every cycle.
module alu_slice
  import tinylab_alu_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  input  alu_func_t          func,
  output logic [SLICE_W-1:0] y,
  output logic               cout
);

  logic [SLICE_W:0] sum;

  // Slice result and carry-out; logical ops and unknown codes produce carry 0.
  always_comb begin
    sum  = '0;
    y    = '0;
    cout = 1'b0;
    case (func)
      ALU_ADD: begin
        sum  = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
        y    = sum[SLICE_W-1:0];
        cout = sum[SLICE_W];
      end
      ALU_SUB: begin
        sum  = {1'b0, a} + {1'b0, ~b} + {{SLICE_W{1'b0}}, cin};
        y    = sum[SLICE_W-1:0];
        cout = sum[SLICE_W];
      end
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_MOVEB: y = b;
      default: begin
        y    = '0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Slice-serial ALU: captures operands on start, processes SLICE_W bits per cycle
// LSB first, and pulses alu_end for one cycle when result is updated.
// Optional feature macro ALU_FLAGS_EN: when defined, flag_z/flag_c registers are
// built and update at completion; otherwise both outputs are tied to 0.
module alu_serial
  import tinylab_alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SLICE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_func,
  input  logic             alu_in_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] result,
  output logic             alu_end,
  output logic             busy,
  output logic             flag_z,
  output logic             flag_c
);

  localparam int N_SLICE = WIDTH / SLICE_W;
  localparam int CNT_W   = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;

  alu_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  alu_func_t          func_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   acc_nxt;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] y_sl;
  logic               cout_sl;
  logic               accept;
  logic               last_slice;

  assign accept     = (state == ALU_IDLE) && start;
  assign last_slice = (cnt_q == CNT_W'(N_SLICE - 1));

  // Select the operand slice addressed by the counter.
  always_comb begin
    a_sl = a_q[cnt_q*SLICE_W +: SLICE_W];
    b_sl = b_q[cnt_q*SLICE_W +: SLICE_W];
  end

  alu_slice #(
    .SLICE_W(SLICE_W)
  ) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .func (func_q),
    .y    (y_sl),
    .cout (cout_sl)
  );

  // Shift the new slice in from the top so that after N_SLICE steps it lands LSB-aligned.
  always_comb begin
    acc_nxt                    = acc_q >> SLICE_W;
    acc_nxt[WIDTH-1 -: SLICE_W] = y_sl;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ALU_IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state logic; start outside IDLE is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      ALU_IDLE: if (start)      state_nxt = ALU_BUSY;
      ALU_BUSY: if (last_slice) state_nxt = ALU_DONE;
      ALU_DONE:                 state_nxt = ALU_IDLE;
      default:                  state_nxt = ALU_IDLE;
    endcase
  end

  // FSM outputs decoded straight from the state flops, so they are glitch-free.
  always_comb begin
    busy    = (state != ALU_IDLE);
    alu_end = (state == ALU_DONE);
  end

  // Slice counter and inter-slice carry; SUB starts with carry 1 to form a + ~b + 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      carry_q <= (alu_func == ALU_SUB);
    end else if (state == ALU_BUSY) begin
      cnt_q   <= last_slice ? '0 : cnt_q + CNT_W'(1);
      carry_q <= cout_sl;
    end
  end

  // Operand capture at start and partial-result accumulation while busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= op_a;
      b_q    <= alu_in_sel ? imm : op_b;
      func_q <= alu_func;
    end else if (state == ALU_BUSY) begin
      acc_q  <= acc_nxt;
    end
  end

  // Visible result updates only on the last-slice edge and holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                result <= '0;
    else if (state == ALU_BUSY && last_slice) result <= acc_nxt;
  end

`ifdef ALU_FLAGS_EN
  logic flag_z_q;
  logic flag_c_q;

  // Zero and MSB-slice carry flags, updated together with result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else if (state == ALU_BUSY && last_slice) begin
      flag_z_q <= (acc_nxt == '0);
      flag_c_q <= cout_sl;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial: table of 8-bit operations plus hand-written
// sequences for ignored restarts, mid-operation reset and a 16-bit instance.
module tb_alu_serial;
  import tinylab_alu_pkg::*;

`ifdef ALU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  alu_func;
  logic        alu_in_sel;
  logic [7:0]  op_a, op_b, imm;
  logic [7:0]  result;
  logic        alu_end, busy, flag_z, flag_c;

  logic        start16;
  logic [2:0]  alu_func16;
  logic        alu_in_sel16;
  logic [15:0] op_a16, op_b16, imm16;
  logic [15:0] result16;
  logic        alu_end16, busy16, flag_z16, flag_c16;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_res;

  always #5 clk = ~clk;

  alu_serial #(.WIDTH(8), .SLICE_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .alu_func(alu_func), .alu_in_sel(alu_in_sel),
    .op_a(op_a), .op_b(op_b), .imm(imm), .result(result), .alu_end(alu_end),
    .busy(busy), .flag_z(flag_z), .flag_c(flag_c)
  );

  alu_serial #(.WIDTH(16), .SLICE_W(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .alu_func(alu_func16), .alu_in_sel(alu_in_sel16),
    .op_a(op_a16), .op_b(op_b16), .imm(imm16), .result(result16), .alu_end(alu_end16),
    .busy(busy16), .flag_z(flag_z16), .flag_c(flag_c16)
  );

  typedef struct {
    string      name;
    logic [2:0] func;
    logic       sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] imm;
    logic [7:0] res;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one 8-bit operation and check latency, result, flags, pulse width and hold.
  task automatic run_op(input vec_t v);
    int lat;
    start = 1'b1; alu_func = v.func; alu_in_sel = v.sel;
    op_a = v.a; op_b = v.b; imm = v.imm;
    tick();
    start = 1'b0; op_a = ~v.a; op_b = ~v.b; imm = ~v.imm;
    chk({v.name, " busy_after_start"}, busy, 1);
    chk({v.name, " no_early_end"}, alu_end, 0);
    lat = 0;
    while (!alu_end && lat < 10) begin
      tick();
      lat++;
      if (!alu_end) chk({v.name, " no_partial_result"}, result, prev_res);
    end
    chk({v.name, " latency"}, lat, 2);
    chk({v.name, " result"}, result, v.res);
    chk({v.name, " flag_z"}, flag_z, FLAGS ? v.z : 1'b0);
    chk({v.name, " flag_c"}, flag_c, FLAGS ? v.c : 1'b0);
    tick();
    chk({v.name, " end_one_cycle"}, alu_end, 0);
    chk({v.name, " busy_clear"}, busy, 0);
    tick();
    chk({v.name, " result_hold"}, result, v.res);
    prev_res = v.res;
  endtask

  initial begin
    int pulses;
    int lat;

    rst = 1'b0; start = 1'b0; alu_func = '0; alu_in_sel = 1'b0;
    op_a = '0; op_b = '0; imm = '0;
    start16 = 1'b0; alu_func16 = '0; alu_in_sel16 = 1'b0;
    op_a16 = '0; op_b16 = '0; imm16 = '0;
    prev_res = 8'h00;

    vecs[0] = '{"add",       ALU_ADD,   1'b0, 8'h5A, 8'h3C, 8'h00, 8'h96, 1'b0, 1'b0};
    vecs[1] = '{"sub_imm_eq", ALU_SUB,  1'b1, 8'h10, 8'h77, 8'h10, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{"sub_borrow", ALU_SUB,  1'b1, 8'h00, 8'h55, 8'h01, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{"and",       ALU_AND,   1'b0, 8'hF0, 8'h3C, 8'h00, 8'h30, 1'b0, 1'b0};
    vecs[4] = '{"or",        ALU_OR,    1'b0, 8'hF0, 8'h3C, 8'h00, 8'hFC, 1'b0, 1'b0};
    vecs[5] = '{"moveb",     ALU_MOVEB, 1'b0, 8'h12, 8'hA5, 8'h66, 8'hA5, 1'b0, 1'b0};
    vecs[6] = '{"illegal",   3'b111,    1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{"add_wrap",  ALU_ADD,   1'b0, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{"moveb_imm", ALU_MOVEB, 1'b1, 8'h00, 8'h00, 8'h3C, 8'h3C, 1'b0, 1'b0};
    vecs[9] = '{"sub_regs",  ALU_SUB,   1'b0, 8'h83, 8'h05, 8'hFF, 8'h7E, 1'b0, 1'b1};

    // Reset state.
    tick();
    tick();
    chk("reset result", result, 0);
    chk("reset alu_end", alu_end, 0);
    chk("reset busy", busy, 0);
    chk("reset flag_z", flag_z, 0);
    chk("reset flag_c", flag_c, 0);
    chk("reset result16", result16, 0);
    chk("reset busy16", busy16, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Start held through BUSY and re-asserted in DONE must be ignored.
    pulses = 0;
    start = 1'b1; alu_func = ALU_ADD; alu_in_sel = 1'b0; op_a = 8'h01; op_b = 8'h02;
    tick();
    op_a = 8'h80; op_b = 8'h80; alu_func = ALU_OR;
    if (alu_end) pulses++;
    tick();
    start = 1'b0;
    if (alu_end) pulses++;
    tick();
    if (alu_end) pulses++;
    chk("restart end_at_e2", alu_end, 1);
    chk("restart result", result, 8'h03);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (alu_end) pulses++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (alu_end) pulses++;
    end
    chk("restart single_pulse", pulses, 1);
    chk("restart result_kept", result, 8'h03);
    chk("restart idle", busy, 0);

    // Reset one cycle after start aborts the operation.
    start = 1'b1; alu_func = ALU_ADD; op_a = 8'h40; op_b = 8'h40;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("abort result", result, 0);
    chk("abort busy", busy, 0);
    chk("abort alu_end", alu_end, 0);
    chk("abort flag_z", flag_z, 0);
    chk("abort flag_c", flag_c, 0);
    tick();
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (alu_end) pulses++;
    end
    chk("abort no_end", pulses, 0);
    prev_res = 8'h00;
    run_op('{"add_after_abort", ALU_ADD, 1'b0, 8'h01, 8'h01, 8'h00, 8'h02, 1'b0, 1'b0});

    // 16-bit instance: four slices with carry rippling through every one.
    start16 = 1'b1; alu_func16 = ALU_ADD; alu_in_sel16 = 1'b0;
    op_a16 = 16'hFFFF; op_b16 = 16'h0001; imm16 = 16'h0000;
    tick();
    start16 = 1'b0; op_a16 = 16'h0000; op_b16 = 16'h0000;
    lat = 0;
    while (!alu_end16 && lat < 12) begin
      tick();
      lat++;
    end
    chk("w16 latency", lat, 4);
    chk("w16 result", result16, 16'h0000);
    chk("w16 flag_c", flag_c16, FLAGS ? 1'b1 : 1'b0);
    chk("w16 flag_z", flag_z16, FLAGS ? 1'b1 : 1'b0);
    tick();
    chk("w16 end_one_cycle", alu_end16, 0);
    chk("w16 busy_clear", busy16, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_serial.md
# alu_serial

Multi-cycle, slice-serial ALU sitting directly downstream of the CPU control state machine. Starts on the control block's one-cycle group-enable pulse and captures the function code, operand-select bit and operands. Processes the operands SLICE_W bits per cycle, LSB first. Returns a one-cycle `alu_end` that moves the controller from Execute to Write_back, and holds `result` stable for the register-file write.

## Interface
Parameters:
- `WIDTH`, 8, datapath width; must be an integer multiple of `SLICE_W`.
- `SLICE_W`, 4, bits processed per cycle. `N_SLICE = WIDTH/SLICE_W`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle start pulse, driven by the controller's group-enable pulse.
- `alu_func`  in  3  operation code: 000 MOVEB, 001 ADD, 010 SUB, 011 AND, 100 OR.
- `alu_in_sel`  in  1  B-operand select: 0 = `op_b`, 1 = `imm`.
- `op_a`  in  WIDTH  operand A (register data).
- `op_b`  in  WIDTH  operand B (register data).
- `imm`  in  WIDTH  immediate operand, already zero-extended.
- `result`  out  WIDTH  registered result.
- `alu_end`  out  1  completion pulse, high for exactly one cycle.
- `busy`  out  1  high in BUSY and DONE.
- `flag_z`  out  1  result == 0. Present only with `ALU_FLAGS_EN`; otherwise 0.
- `flag_c`  out  1  carry out of the MSB slice. Present only with `ALU_FLAGS_EN`; otherwise 0.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE → BUSY** on an edge where `start`=1.
  - Latch `a` = `op_a`.
  - Latch `b` = `alu_in_sel` ? `imm` : `op_b`.
  - Latch `func`.
  - Set slice counter = 0.
  - Initialise carry: 1 for SUB, otherwise 0.
- **BUSY:** each edge computes slice [cnt*SLICE_W +: SLICE_W] into the result shift register and registers the slice carry-out.
  - ADD: a+b+c.
  - SUB: a+~b+c.
  - AND, OR: bitwise.
  - MOVEB: b.
  - Codes 101–111: slice result 0, carry 0; the operation still completes normally.
- **BUSY → DONE** on the edge that processes slice N_SLICE-1. `result`, `flag_z` and `flag_c` update on that edge.
- **DONE → IDLE** unconditionally on the next edge.
- `start` in BUSY or DONE is ignored. No queuing, no restart.
- `result` and flags hold their value until the last-slice edge of the next operation. Intermediate slices go into an internal shift register, so `result` never shows partial values.
- SUB `flag_c` = 1 means no borrow.
- Reset (any time, including mid-operation) forces:
  - state IDLE, `result`=0, `alu_end`=0, `busy`=0;
  - `flag_z`=0, `flag_c`=0, counter=0.
  - An aborted operation never raises `alu_end`.

## Timing
- Edge E0 samples `start`=1.
- `busy` is high from E0 until E(N_SLICE+1).
- `alu_end` is high from edge E(N_SLICE) to E(N_SLICE+1). With defaults (N_SLICE=2): high from E2 to E3.
- Latency from start edge to `alu_end` rising is N_SLICE cycles.
- `alu_end` is a registered output, so the controller sees it as a clean combinational input to its next-state logic.
- `result` is valid at the `alu_end` rising edge and stays stable through Write_back and beyond.
- Back-to-back operations: earliest accepted `start` is the edge after DONE, i.e. one IDLE cycle minimum. This matches the controller's Write_back → Fetch → Decode sequence.
- `op_a`/`op_b`/`imm` may change after E0 without affecting the operation.

## Configuration
- Macro: `ALU_FLAGS_EN`.
- **Defined:** the `flag_z` and `flag_c` registers are implemented and update at completion as above.
- **Undefined:** the flag registers are not instantiated. `flag_z`/`flag_c` are tied to 0 and the port list is unchanged.

## Structure
- Package `tinylab_alu_pkg` holds:
  - func code constants `ALU_MOVEB`, `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`;
  - FSM state encoding `ALU_IDLE`, `ALU_BUSY`, `ALU_DONE`.
- Sub-module `alu_slice`: combinational SLICE_W-bit unit.
  - Inputs: a, b, cin, func.
  - Outputs: y, cout.
  - Instantiated once and reused every cycle.

## Test plan
- ADD, `op_a`=8'h5A, `op_b`=8'h3C, sel 0 -> `alu_end` pulses 2 cycles after start; `result`=8'h96, flag_c=0, flag_z=0.
- SUB with immediate, `op_a`=8'h10, `imm`=8'h10, sel 1 -> `result`=8'h00, flag_z=1, flag_c=1. Then `op_a`=8'h00, `imm`=8'h01 -> `result`=8'hFF, flag_c=0.
- AND 8'hF0 & 8'h3C -> 8'h30; OR -> 8'hFC; MOVEB `op_b`=8'hA5 -> 8'hA5. `result` holds between operations.
- Start pulse repeated in BUSY and in DONE -> ignored; exactly one `alu_end` and an unchanged result.
- Reset asserted one cycle after start -> all outputs 0, no `alu_end`. A new ADD 8'h01+8'h01 then completes normally with 8'h02.
- Illegal func 3'b111 -> completes in N_SLICE cycles with `result`=0. Rebuild with WIDTH=16, SLICE_W=4 and run 16'hFFFF+16'h0001 -> latency 4 cycles, `result`=0, flag_c=1.
